scan_reg_bank: RTL and testbench

SCAN_REG_BANK -- requirements
Module: scan_reg_bank

---
 rtl/scan_reg_bank.sv | 54 +++++
 tb/tb_scan_reg_bank.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/scan_reg_bank.sv
// Scannable parallel register with synchronous reset/preset, capture enable,
// and a shift-length counter that pulses SCAN_DONE once per full chain shift.
module scan_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}},
  localparam int              CW        = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SET,
  input  logic             SE,
  input  logic             SI,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic [CW-1:0]    SHIFT_CNT,
  output logic             SCAN_DONE
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q         <= RESET_VAL;
      SHIFT_CNT <= '0;
      SCAN_DONE <= 1'b0;
    end else if (SET) begin
      Q         <= SET_VAL;
      SHIFT_CNT <= '0;
      SCAN_DONE <= 1'b0;
    end else if (SE) begin
      Q <= {Q[WIDTH-2:0], SI};
      // Completing the last bit of a chain wraps the count and flags done.
      if (SHIFT_CNT == LAST_CNT) begin
        SHIFT_CNT <= '0;
        SCAN_DONE <= 1'b1;
      end else begin
        SHIFT_CNT <= SHIFT_CNT + CW'(1);
        SCAN_DONE <= 1'b0;
      end
    end else begin
      if (EN) Q <= D;
      SHIFT_CNT <= '0;
      SCAN_DONE <= 1'b0;
    end
  end

  assign QN = ~Q;
  assign SO = Q[WIDTH-1];

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed and randomized checks of scan_reg_bank (WIDTH=8) against a
// behavioural model that tracks the length of the current shift run.
module tb_scan_reg_bank;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0, SET = 1'b0, SE = 1'b0, SI = 1'b0, EN = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q, QN;
  logic         SO;
  logic [2:0]   SHIFT_CNT;
  logic         SCAN_DONE;

  int checks = 0;
  int errors = 0;

  // Reference model: register value plus number of consecutive shift edges.
  logic [W-1:0] m_q;
  int           m_run;
  logic         m_done;

  scan_reg_bank #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .SET(SET), .SE(SE), .SI(SI), .EN(EN), .D(D),
    .Q(Q), .QN(QN), .SO(SO), .SHIFT_CNT(SHIFT_CNT), .SCAN_DONE(SCAN_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (RST) begin
      m_q = 8'h00; m_run = 0; m_done = 1'b0;
    end else if (SET) begin
      m_q = 8'hFF; m_run = 0; m_done = 1'b0;
    end else if (SE) begin
      m_q    = W'((m_q * 2 + SI) % 256);
      m_run  = m_run + 1;
      m_done = (m_run % W) == 0;
    end else begin
      if (EN) m_q = D;
      m_run = 0; m_done = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},    Q,         m_q);
    chk({tag, ".qn"},   QN,        8'hFF - m_q);
    chk({tag, ".so"},   SO,        m_q / 128);
    chk({tag, ".cnt"},  SHIFT_CNT, m_run % W);
    chk({tag, ".done"}, SCAN_DONE, m_done);
  endtask

  task automatic step(input logic rst, input logic set, input logic se,
                      input logic si, input logic en, input logic [W-1:0] d,
                      input string tag);
    @(negedge CLK);
    RST = rst; SET = set; SE = se; SI = si; EN = en; D = d;
    @(posedge CLK);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [W-1:0] pat;
    m_q = 'x; m_run = 0; m_done = 1'b0;

    // Reset dominates SET and SE
    step(1, 1, 1, 1, 1, 8'h5A, "reset");
    chk("reset.q_const", Q, 8'h00);
    chk("reset.qn_const", QN, 8'hFF);

    // Capture then hold
    step(0, 0, 0, 0, 1, 8'hA5, "capture");
    step(0, 0, 0, 0, 0, 8'h3C, "hold");
    chk("hold.q_const", Q, 8'hA5);
    chk("hold.qn_const", QN, 8'h5A);

    // Full shift from zero: 1,0,1,1,0,0,1,0
    step(1, 0, 0, 0, 0, 8'h00, "rst2");
    pat = 8'b1011_0010;
    for (int i = 0; i < W; i++) begin
      step(0, 0, 1, pat[W-1-i], 1, 8'hFF, "shift");
      if (i < W - 1) chk("shift.no_done", SCAN_DONE, 1'b0);
    end
    chk("shift.q_const", Q, 8'hB2);
    chk("shift.cnt_wrap", SHIFT_CNT, 3'd0);
    chk("shift.done_pulse", SCAN_DONE, 1'b1);
    step(0, 0, 0, 0, 0, 8'h00, "shift_after");
    chk("shift.done_clear", SCAN_DONE, 1'b0);

    // Interrupted shift: 5, one idle edge, then 8
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1'(i), 0, 8'h00, "part");
    chk("part.no_done", SCAN_DONE, 1'b0);
    step(0, 0, 0, 0, 0, 8'h00, "interrupt");
    chk("interrupt.cnt", SHIFT_CNT, 3'd0);
    for (int i = 0; i < W; i++) begin
      step(0, 0, 1, 1'(i), 0, 8'h00, "resume");
      if (i < W - 1) chk("resume.no_done", SCAN_DONE, 1'b0);
    end
    chk("resume.done", SCAN_DONE, 1'b1);

    // Priority: SET mid-chain, then RST+SET
    step(0, 0, 0, 0, 0, 8'h00, "pri_idle");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 8'h00, "pri_shift");
    chk("pri.cnt3", SHIFT_CNT, 3'd3);
    step(0, 1, 1, 0, 1, 8'h12, "pri_set");
    chk("pri.set_q", Q, 8'hFF);
    chk("pri.set_cnt", SHIFT_CNT, 3'd0);
    step(1, 1, 1, 0, 1, 8'h12, "pri_rst");
    chk("pri.rst_q", Q, 8'h00);
    step(0, 0, 1, 1, 0, 8'h00, "pri_restart");
    chk("pri.restart_cnt", SHIFT_CNT, 3'd1);

    // Scan-out chaining
    step(0, 0, 0, 0, 1, 8'h80, "so_load");
    chk("so.before", SO, 1'b1);
    step(0, 0, 1, 0, 1, 8'hFF, "so_shift");
    chk("so.after", SO, 1'b0);
    chk("so.q", Q, 8'h00);

    // D = X ignored on the shift path
    step(0, 0, 1, 1, 1, 8'hxx, "x_on_d");
    chk("x_on_d.q", Q, 8'h01);

    // Randomized traffic, biased toward long shift runs
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 47) == 0,
           $urandom_range(0, 99) < 80, 1'($urandom), 1'($urandom),
           W'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
